map_view_ctrl: RTL and testbench
================================

Name: map_view_ctrl

Overview:
- Camera/view configuration controller for the Mode-7 map renderer.
- Turns held user buttons into stepped changes of view angle, near magnitude and far magnitude. Also accepts ball-position updates.
- Holds all edits in pending registers. Commits them atomically to the renderer-facing outputs once per frame, at the start of vertical blanking, so one frame never mixes two parameter sets.

Parameters:
- REPEAT_CYCLES, 100000: cycles a button must stay held between successive steps.
- V_ACTIVE, 720: first blanking line; the commit boundary is vcount_in==V_ACTIVE && hcount_in==0.
- ANGLE_INIT, 0: angle after reset, in degrees.
- FAR_INIT, 17: far_mag after reset.
- NEAR_INIT, 0: near_mag after reset.
- MAG_MAX, 255: upper saturation limit for far_mag.

Ports:
- pixel_clk_in  input  1  pixel clock; all logic on its rising edge.
- rst_in  input  1  synchronous, active-high reset.
- hcount_in  input  11  horizontal pixel count.
- vcount_in  input  10  vertical line count.
- rot_btn_in  input  2  [0] angle +1, [1] angle -1.
- change_in  input  4  [0] far +1, [1] far -1, [2] near +1, [3] near -1.
- ball_valid_in  input  1  one-cycle strobe: new ball position.
- ballx_in  input  16  ball x, map units.
- bally_in  input  16  ball y, map units.
- angle_out  output  16  committed angle, range 0..359.
- far_mag_out  output  20  committed far magnitude.
- near_mag_out  output  20  committed near magnitude.
- ballx_out  output  16  committed ball x.
- bally_out  output  16  committed ball y.
- frame_update_out  output  1  one-cycle pulse in the cycle the outputs take new values.
- debug_out  output  32  status word (see Optional Feature).

Behaviour:
- Reset state:
  - Pending and committed registers take the INIT values; ballx/bally take 0.
  - frame_update_out=0; FSM in IDLE; all repeat counters 0.
  - Reset mid-hold cancels the hold; the button must stay held a full REPEAT_CYCLES after reset is released.
- Hold-repeat, per channel (rotate, far, near):
  - A step pulse fires on the first cycle a direction is seen high, since its counter is 0.
  - The counter then counts held cycles. When it reaches REPEAT_CYCLES-1 it fires another pulse and returns to 0.
  - Releasing the button clears the counter.
  - Both directions of one channel high: no step, counter held at 0.
- Angle update:
  - +1 wraps 359->0; -1 wraps 0->359.
  - Only one step is possible per cycle.
- Far update:
  - +1 only if pending far < MAG_MAX.
  - -1 only if pending far > pending near.
  - Otherwise saturate silently.
- Near update:
  - +1 only if pending near < pending far.
  - -1 only if pending near > 0.
  - Invariant at all times: 0 <= near <= far <= MAG_MAX.
- Mixed steps in one cycle:
  - Far and near steps in the same cycle are evaluated against the old pending values, in this order: far first, then near re-checked against the new far.
  - Example: far--, near++ with far==near+1 gives far=near+1-1 and rejects near++.
- Ball update: ball_valid_in copies ballx_in/bally_in into pending. The newest strobe before the boundary wins.
- FSM:
  - IDLE: pending == committed. Any accepted step or ball strobe moves to DIRTY.
  - DIRTY: wait for the boundary; at the boundary move to COMMIT.
  - COMMIT (1 cycle): committed <= pending; frame_update_out=1 in the next cycle, together with the new outputs.
  - After COMMIT: go to DIRTY if an edit was accepted during the COMMIT cycle (that edit is not lost; it lands next frame), otherwise IDLE.
- Latency: outputs change exactly 2 cycles after the boundary cycle (boundary -> COMMIT -> registered outputs).
- Boundary while IDLE: no pulse, outputs unchanged.
- At most one commit per frame. If the boundary condition is held over several cycles, a commit fires only on the first of them.

Optional Feature:
- Macro: MAP_VIEW_DEBUG_EN.
- Defined: debug_out = {fsm_state[1:0], 2'b0, pending_angle[8:0], 3'b0, committed_far[7:0], committed_near[7:0]}.
- Not defined: debug_out is tied to 32'h0, and no debug logic is synthesized.

Decomposition:
- Package map_view_pkg holds:
  - enum view_state_t {IDLE, DIRTY, COMMIT}.
  - ANGLE_MAX=359.
  - Magnitude width 20 and angle width 16.
  - Default INIT constants.
- One sub-module, hold_repeat:
  - Ports: clock, reset, up, down.
  - Outputs: step_up and step_down pulses.
  - Parameter: REPEAT_CYCLES.
  - Instantiated three times.

Test Plan (REPEAT_CYCLES=4):
- Reset -> angle_out=0, far_mag_out=17, near_mag_out=0, frame_update_out=0; no pulse at the first boundary.
- Hold rot_btn_in[0] for 9 cycles, then hit the boundary -> pending angle steps at cycles 0, 4, 8 (3 steps). angle_out=3 exactly 2 cycles after the boundary, with a single frame_update_out pulse.
- Angle at 359, one +1 press -> 0 after commit. Angle at 0, one -1 press -> 359.
- far=17, near=16, press change_in[1] -> far=16. Press again -> far stays 16. Press change_in[2] -> near stays 16.
- change_in[0] and change_in[1] held together for 20 cycles -> far unchanged, no commit pulse.
- ball_valid_in twice before the boundary ((5,7) then (9,11)) -> ballx_out=9 and bally_out=11 after commit. A strobe during the COMMIT cycle appears one frame later.

Source files
------------

// File: rtl/map_view_pkg.sv
// Shared types, widths and reset defaults for the Mode-7 map view controller.
package map_view_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRTY  = 2'd1,
    COMMIT = 2'd2
  } view_state_t;

  localparam int ANGLE_MAX = 359;
  localparam int ANGLE_W   = 16;
  localparam int MAG_W     = 20;
  localparam int BALL_W    = 16;

  localparam int REPEAT_CYCLES_DEF = 100000;
  localparam int V_ACTIVE_DEF      = 720;
  localparam int ANGLE_INIT_DEF    = 0;
  localparam int FAR_INIT_DEF      = 17;
  localparam int NEAR_INIT_DEF     = 0;
  localparam int MAG_MAX_DEF       = 255;

  // One-degree step with wrap in both directions; up has priority if both set.
  function automatic logic [ANGLE_W-1:0] angle_step(
    input logic [ANGLE_W-1:0] a,
    input logic               up,
    input logic               dn
  );
    logic [ANGLE_W-1:0] r;
    r = a;
    if (up) begin
      r = (a == ANGLE_W'(ANGLE_MAX)) ? '0 : a + ANGLE_W'(1);
    end else if (dn) begin
      r = (a == '0) ? ANGLE_W'(ANGLE_MAX) : a - ANGLE_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/map_view_ctrl_hold_repeat.sv
// Held-button auto-repeat: one step on press, then one step every REPEAT_CYCLES held cycles.
module hold_repeat #(
  parameter int REPEAT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_up,
  input  logic i_down,
  output logic o_step_up,
  output logic o_step_down
);

  localparam int CNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic             w_held;
  logic             w_fire;

  assign w_held      = i_up ^ i_down;
  assign w_fire      = w_held && (!r_active || (r_cnt == TC));
  assign o_step_up   = w_fire && i_up;
  assign o_step_down = w_fire && i_down;

  // Reset leaves the channel "already counting" so a button held through
  // reset needs a full repeat period before it steps again.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (!w_held) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (!r_active) begin
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_cnt == TC) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/map_view_ctrl.sv
// View parameter controller: edits go to pending registers, committed once per frame at vblank.
// Optional status word enabled by defining MAP_VIEW_DEBUG_EN.
//
// state  | meaning
// IDLE   | pending == committed
// DIRTY  | pending holds edits, waiting for the vblank boundary
// COMMIT | one cycle: committed <= pending
module map_view_ctrl
  import map_view_pkg::*;
#(
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int V_ACTIVE      = V_ACTIVE_DEF,
  parameter int ANGLE_INIT    = ANGLE_INIT_DEF,
  parameter int FAR_INIT      = FAR_INIT_DEF,
  parameter int NEAR_INIT     = NEAR_INIT_DEF,
  parameter int MAG_MAX       = MAG_MAX_DEF
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  input  logic [10:0]         hcount_in,
  input  logic [9:0]          vcount_in,
  input  logic [1:0]          rot_btn_in,
  input  logic [3:0]          change_in,
  input  logic                ball_valid_in,
  input  logic [BALL_W-1:0]   ballx_in,
  input  logic [BALL_W-1:0]   bally_in,
  output logic [ANGLE_W-1:0]  angle_out,
  output logic [MAG_W-1:0]    far_mag_out,
  output logic [MAG_W-1:0]    near_mag_out,
  output logic [BALL_W-1:0]   ballx_out,
  output logic [BALL_W-1:0]   bally_out,
  output logic                frame_update_out,
  output logic [31:0]         debug_out
);

  localparam logic [MAG_W-1:0]   MAG_LIM   = MAG_W'(MAG_MAX);
  localparam logic [MAG_W-1:0]   FAR_RST   = MAG_W'(FAR_INIT);
  localparam logic [MAG_W-1:0]   NEAR_RST  = MAG_W'(NEAR_INIT);
  localparam logic [ANGLE_W-1:0] ANGLE_RST = ANGLE_W'(ANGLE_INIT);

  view_state_t r_state, w_state_nxt;

  logic [ANGLE_W-1:0] r_pend_angle, r_com_angle, w_angle_nxt;
  logic [MAG_W-1:0]   r_pend_far, r_com_far, w_far_nxt;
  logic [MAG_W-1:0]   r_pend_near, r_com_near, w_near_nxt;
  logic [BALL_W-1:0]  r_pend_bx, r_pend_by, r_com_bx, r_com_by;
  logic               r_frame_update;
  logic               r_bnd_d;

  logic w_rot_up, w_rot_dn, w_far_up, w_far_dn, w_near_up, w_near_dn;
  logic w_bnd, w_bnd_edge, w_edit, w_commit;

  hold_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_rot (
    .i_clk(pixel_clk_in), .i_rst(rst_in),
    .i_up(rot_btn_in[0]), .i_down(rot_btn_in[1]),
    .o_step_up(w_rot_up), .o_step_down(w_rot_dn)
  );

  hold_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_far (
    .i_clk(pixel_clk_in), .i_rst(rst_in),
    .i_up(change_in[0]), .i_down(change_in[1]),
    .o_step_up(w_far_up), .o_step_down(w_far_dn)
  );

  hold_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_near (
    .i_clk(pixel_clk_in), .i_rst(rst_in),
    .i_up(change_in[2]), .i_down(change_in[3]),
    .o_step_up(w_near_up), .o_step_down(w_near_dn)
  );

  assign w_bnd      = (vcount_in == 10'(V_ACTIVE)) && (hcount_in == '0);
  assign w_bnd_edge = w_bnd && !r_bnd_d;
  assign w_angle_nxt = angle_step(r_pend_angle, w_rot_up, w_rot_dn);

  // Far is resolved first; near is then checked against the updated far.
  always_comb begin
    w_far_nxt = r_pend_far;
    if (w_far_up && (r_pend_far < MAG_LIM)) begin
      w_far_nxt = r_pend_far + MAG_W'(1);
    end else if (w_far_dn && (r_pend_far > r_pend_near)) begin
      w_far_nxt = r_pend_far - MAG_W'(1);
    end
    w_near_nxt = r_pend_near;
    if (w_near_up && (r_pend_near < w_far_nxt)) begin
      w_near_nxt = r_pend_near + MAG_W'(1);
    end else if (w_near_dn && (r_pend_near != '0)) begin
      w_near_nxt = r_pend_near - MAG_W'(1);
    end
  end

  assign w_edit = w_rot_up | w_rot_dn | ball_valid_in |
                  (w_far_nxt != r_pend_far) | (w_near_nxt != r_pend_near);

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_bnd_d <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bnd_d <= w_bnd;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_edit) w_state_nxt = DIRTY;
      DIRTY:   if (w_bnd_edge) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = w_edit ? DIRTY : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_commit = (r_state == COMMIT);
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_pend_angle <= ANGLE_RST;
      r_pend_far   <= FAR_RST;
      r_pend_near  <= NEAR_RST;
      r_pend_bx    <= '0;
      r_pend_by    <= '0;
    end else begin
      r_pend_angle <= w_angle_nxt;
      r_pend_far   <= w_far_nxt;
      r_pend_near  <= w_near_nxt;
      if (ball_valid_in) begin
        r_pend_bx <= ballx_in;
        r_pend_by <= bally_in;
      end
    end
  end

  // Committed copy samples pending before any same-cycle edit lands.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_com_angle    <= ANGLE_RST;
      r_com_far      <= FAR_RST;
      r_com_near     <= NEAR_RST;
      r_com_bx       <= '0;
      r_com_by       <= '0;
      r_frame_update <= 1'b0;
    end else begin
      r_frame_update <= w_commit;
      if (w_commit) begin
        r_com_angle <= r_pend_angle;
        r_com_far   <= r_pend_far;
        r_com_near  <= r_pend_near;
        r_com_bx    <= r_pend_bx;
        r_com_by    <= r_pend_by;
      end
    end
  end

  assign angle_out        = r_com_angle;
  assign far_mag_out      = r_com_far;
  assign near_mag_out     = r_com_near;
  assign ballx_out        = r_com_bx;
  assign bally_out        = r_com_by;
  assign frame_update_out = r_frame_update;

`ifdef MAP_VIEW_DEBUG_EN
  assign debug_out = {r_state[1:0], 2'b0, r_pend_angle[8:0], 3'b0,
                      r_com_far[7:0], r_com_near[7:0]};
`else
  assign debug_out = 32'h0;
`endif

endmodule

// File: tb/tb_map_view_ctrl.sv
// Scoreboard bench for map_view_ctrl: reference model pushes expected commits, monitor pops on frame_update_out.
module tb_map_view_ctrl;

  localparam int R    = 4;
  localparam int VA   = 720;
  localparam int MAXM = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hc  = '0;
  logic [9:0]  vc  = '0;
  logic [1:0]  rot = '0;
  logic [3:0]  chg = '0;
  logic        bv  = 1'b0;
  logic [15:0] bx  = '0;
  logic [15:0] by  = '0;

  logic [15:0] angle_out;
  logic [19:0] far_out, near_out;
  logic [15:0] bx_out, by_out;
  logic        fu;
  logic [31:0] dbg;

  map_view_ctrl #(.REPEAT_CYCLES(R)) dut (
    .pixel_clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc),
    .rot_btn_in(rot), .change_in(chg), .ball_valid_in(bv),
    .ballx_in(bx), .bally_in(by),
    .angle_out(angle_out), .far_mag_out(far_out), .near_mag_out(near_out),
    .ballx_out(bx_out), .bally_out(by_out),
    .frame_update_out(fu), .debug_out(dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int angle; int far; int near; int bx; int by; int t;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, pulses = 0;

  // reference model state
  int m_ang, m_far, m_near, m_bx, m_by;
  int m_run[3];
  bit m_bnd_prev, m_dirty, m_commit_now;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    m_ang = 0; m_far = 17; m_near = 0; m_bx = 0; m_by = 0;
    for (int k = 0; k < 3; k++) m_run[k] = 1;
    m_bnd_prev = 0; m_dirty = 0; m_commit_now = 0;
  endtask

  task automatic model_cycle();
    logic [1:0] ud[3];
    bit st_up[3], st_dn[3];
    bit bnd, edge_b, edit;
    int nf, nn;
    exp_t e;
    ud[0] = rot; ud[1] = chg[1:0]; ud[2] = chg[3:2];
    for (int k = 0; k < 3; k++) begin
      st_up[k] = 0; st_dn[k] = 0;
      if (ud[k] == 2'b01 || ud[k] == 2'b10) begin
        if (m_run[k] % R == 0) begin
          st_up[k] = ud[k][0]; st_dn[k] = ud[k][1];
        end
        m_run[k]++;
      end else begin
        m_run[k] = 0;
      end
    end
    bnd = (vc == 10'(VA)) && (hc == 11'd0);
    edge_b = bnd && !m_bnd_prev;
    m_bnd_prev = bnd;
    if (m_commit_now) begin
      e.angle = m_ang; e.far = m_far; e.near = m_near;
      e.bx = m_bx; e.by = m_by; e.t = cyc + 1;
      q.push_back(e);
    end
    edit = 0;
    if (st_up[0]) begin m_ang = (m_ang + 1) % 360; edit = 1; end
    if (st_dn[0]) begin m_ang = (m_ang + 359) % 360; edit = 1; end
    nf = m_far;
    if (st_up[1] && m_far < MAXM) nf = m_far + 1;
    if (st_dn[1] && m_far > m_near) nf = m_far - 1;
    nn = m_near;
    if (st_up[2] && m_near < nf) nn = m_near + 1;
    if (st_dn[2] && m_near > 0) nn = m_near - 1;
    if (nf != m_far || nn != m_near) edit = 1;
    m_far = nf; m_near = nn;
    if (bv) begin m_bx = bx; m_by = by; edit = 1; end
    if (m_commit_now) begin
      m_dirty = edit; m_commit_now = 0;
    end else if (m_dirty && edge_b) begin
      m_commit_now = 1;
    end else if (edit) begin
      m_dirty = 1;
    end
  endtask

  task automatic tick();
    if (rst) model_reset();
    else model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rot = '0; chg = '0; bv = 1'b0; vc = '0;
    repeat (n) tick();
  endtask

  task automatic press_rot(input logic [1:0] v);
    rot = v; tick(); rot = '0; tick();
  endtask

  task automatic press_chg(input logic [3:0] v);
    chg = v; tick(); chg = '0; tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin tick(); n++; end
    chk("drain_outstanding", q.size(), 0);
    q.delete();
  endtask

  task automatic frame();
    rot = '0; chg = '0; bv = 1'b0;
    vc = 10'(VA); tick();
    idle(4);
    drain();
  endtask

  // monitor / scoreboard
  int l_ang = 0, l_far = 17, l_near = 0, l_bx = 0, l_by = 0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      l_ang = 0; l_far = 17; l_near = 0; l_bx = 0; l_by = 0;
    end else if (fu) begin
      pulses++;
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc, e.t);
        chk("angle", int'(angle_out), e.angle);
        chk("far", int'(far_out), e.far);
        chk("near", int'(near_out), e.near);
        chk("ballx", int'(bx_out), e.bx);
        chk("bally", int'(by_out), e.by);
      end
      chk("invariant", int'(near_out <= far_out && far_out <= 20'(MAXM)), 1);
      l_ang = angle_out; l_far = far_out; l_near = near_out;
      l_bx = bx_out; l_by = by_out;
    end else begin
      chk("stable_no_pulse",
          int'(angle_out == 16'(l_ang) && far_out == 20'(l_far) && near_out == 20'(l_near) &&
               bx_out == 16'(l_bx) && by_out == 16'(l_by)), 1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int p0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_angle", int'(angle_out), 0);
    chk("rst_far", int'(far_out), 17);
    chk("rst_near", int'(near_out), 0);
    chk("rst_fu", int'(fu), 0);
    idle(2);

    p0 = pulses; frame();
    chk("first_boundary_no_pulse", pulses - p0, 0);

    // 9-cycle hold: steps at held cycles 0, 4, 8
    rot = 2'b01; repeat (9) tick(); rot = '0; tick();
    p0 = pulses; frame();
    chk("hold9_angle", int'(angle_out), 3);
    chk("hold9_pulses", pulses - p0, 1);

    repeat (3) press_rot(2'b10);
    frame(); chk("angle_down_to_0", int'(angle_out), 0);
    press_rot(2'b10);
    frame(); chk("angle_wrap_0_to_359", int'(angle_out), 359);
    press_rot(2'b01);
    frame(); chk("angle_wrap_359_to_0", int'(angle_out), 0);

    repeat (16) press_chg(4'b0100);
    frame(); chk("near_16", int'(near_out), 16);
    press_chg(4'b0010);
    frame(); chk("far_16", int'(far_out), 16);
    press_chg(4'b0010);
    press_chg(4'b0100);
    p0 = pulses; frame();
    chk("saturate_no_pulse", pulses - p0, 0);
    chk("far_stays_16", int'(far_out), 16);
    chk("near_stays_16", int'(near_out), 16);

    chg = 4'b0011; repeat (20) tick(); chg = '0; tick();
    p0 = pulses; frame();
    chk("both_dirs_no_pulse", pulses - p0, 0);
    chk("both_dirs_far", int'(far_out), 16);

    press_chg(4'b1000);
    frame(); chk("near_15", int'(near_out), 15);
    chg = 4'b0110; tick(); chg = '0; tick();
    frame();
    chk("mixed_far", int'(far_out), 15);
    chk("mixed_near", int'(near_out), 15);

    bx = 16'd5; by = 16'd7; bv = 1'b1; tick(); bv = 1'b0; tick();
    bx = 16'd9; by = 16'd11; bv = 1'b1; tick(); bv = 1'b0; tick(); tick();
    vc = 10'(VA); tick(); vc = '0;
    bx = 16'd20; by = 16'd30; bv = 1'b1; tick(); bv = 1'b0;
    idle(4); drain();
    chk("ball_x_newest", int'(bx_out), 9);
    chk("ball_y_newest", int'(by_out), 11);
    frame();
    chk("ball_x_next_frame", int'(bx_out), 20);
    chk("ball_y_next_frame", int'(by_out), 30);

    // boundary held 3 cycles, edit during commit cycle
    press_rot(2'b01);
    p0 = pulses;
    vc = 10'(VA); tick();
    rot = 2'b01; tick();
    rot = '0; tick();
    idle(4); drain();
    chk("held_bnd_pulses", pulses - p0, 1);
    chk("held_bnd_angle", int'(angle_out), 1);
    frame();
    chk("commit_edit_next_frame", int'(angle_out), 2);

    chg = 4'b0001; repeat (1000) tick(); chg = '0; tick();
    frame(); chk("far_max", int'(far_out), MAXM);
    press_chg(4'b0001);
    p0 = pulses; frame();
    chk("far_max_no_pulse", pulses - p0, 0);

    // button held through reset needs a full repeat period
    rot = 2'b01; tick(); tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    repeat (6) tick();
    rot = '0; tick();
    frame();
    chk("reset_mid_hold_angle", int'(angle_out), 1);

    for (int f = 0; f < 60; f++) begin
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 7) == 0) rot = 2'($urandom);
        if ($urandom_range(0, 7) == 0) chg = 4'($urandom);
        bv = ($urandom_range(0, 9) == 0);
        bx = 16'($urandom); by = 16'($urandom);
        hc = (i == 0 || i == 1) ? 11'd0 : 11'($urandom_range(0, 3));
        vc = (i == 0 || (i == 1 && f % 2 == 1)) ? 10'(VA) : 10'($urandom_range(0, 719));
        tick();
      end
    end
    hc = '0;
    idle(2);
    frame();
    frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
